spi_write_master: RTL and testbench
===================================

Name: spi_write_master

Overview:
- SPI controller: the transmitting end of the write link served by the `spi` receiver block.
- Accepts one write request (8-bit command, 24-bit address, 32-bit data) via a valid/ready handshake.
- Serialises it as a 64-bit MSB-first frame on `sck`/`cs`/`copi`, SPI mode 0.
- Sits between on-chip control logic and the external or on-chip `spi` write port.

Parameters:
- CLK_DIV, 2, number of `clk` cycles per `sck` half-period (≥1); bit period = 2*CLK_DIV cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_cmd  input  8  command byte; first on the wire.
- req_addr  input  24  write address; second on the wire.
- req_data  input  32  write data; last on the wire.
- busy  output  1  high from accept until frame and gap complete.
- done  output  1  one-cycle pulse at end of transaction.
- sck  output  1  SPI clock, idles low.
- cs  output  1  chip select, active-low, idles high.
- copi  output  1  serial data, MSB first.

Behaviour:
- Reset (async, any time, including mid-frame): cs=1, sck=0, copi=0, busy=0, done=0, req_ready=1 after release. State=IDLE, counters cleared, shift register cleared. Aborted frames are not resumed.
- All outputs are registered; no combinational paths from inputs to sck/cs/copi.
- Accept: on a rising edge with req_valid&req_ready, latch {req_cmd,req_addr,req_data} into a 64-bit shift register, set busy=1 and req_ready=0. Input changes after accept have no effect.
- States: IDLE -> SHIFT -> TRAIL -> GAP -> IDLE.
- SHIFT, cycle after accept: cs=0, copi=bit63, sck=0.
  - Each bit: CLK_DIV cycles sck=0, then CLK_DIV cycles sck=1.
  - On the sck 1->0 transition, shift left and drive the next bit on copi.
  - copi is stable across every sck rising edge.
  - Exactly 64 sck rising edges per frame; a 7-bit bit counter ends SHIFT after bit 0's high phase.
- TRAIL: sck=0, cs=0, copi holds bit0 for CLK_DIV cycles. Total cs-low time = 129*CLK_DIV cycles (258 at default).
- GAP: cs=1, copi=0, sck=0 for CLK_DIV cycles. Guarantees a minimum inter-frame deselect.
- Leaving GAP: done=1 for one cycle, busy=0, req_ready=1 in the same cycle. A request held valid is accepted on that edge (back-to-back).
- req_valid while busy: ignored; no queueing.
- CLK_DIV=1: sck toggles every cycle; the same sequence holds.
- Half-period counter width is $clog2(CLK_DIV)+1; it wraps to 0 at each phase boundary.
- sck never toggles while cs=1.

Test Plan:
- Single frame, CLK_DIV=2, cmd=8'hA4, addr=24'h123456, data=32'hDEADBEEF -> bench samples copi on 64 sck rising edges = 64'hA4123456DEADBEEF; cs low exactly 258 clk cycles; one done pulse; `spi` receiver shows wr_en with address 24'h123456, data 32'hDEADBEEF.
- Back-to-back: hold req_valid with second request {8'hA1,24'hABCDEF,32'h01234567} -> accepted on done cycle; cs high ≥2 cycles between frames; second frame decodes 64'hA1ABCDEF01234567.
- Input stability: change req_* and pulse req_valid during busy -> frame unchanged, req_ready=0 throughout, no extra frame.
- Reset at sck rising edge #20 -> cs=1, sck=0, copi=0 asynchronously (before next clk edge); after release req_ready=1; new frame 64'hFFFFFFFFFFFFFFFF transmits cleanly.
- CLK_DIV=1 with alternating 64'hAAAAAAAAAAAAAAAA and then all-zero data -> sck period 2 cycles, 64 edges each, cs low 129 cycles, correct decode.
- Idle check: no request for 1000 cycles after reset -> cs=1, sck=0, busy=0, done never asserted.

Source files
------------

// File: rtl/spi_write_master_if.sv
// spi_write_master_if: write-request handshake between control logic and the SPI write master.
interface spi_write_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [23:0] req_addr;
    logic [31:0] req_data;
    modport master (output req_valid, req_cmd, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_cmd, req_addr, req_data, output req_ready);
endinterface

// File: rtl/spi_write_master.sv
// spi_write_master: serialises one {cmd,addr,data} write as a 64-bit MSB-first SPI mode-0 frame.
module spi_write_master #(
    parameter int CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                rst,
    spi_write_master_if.slave   req,
    output logic                busy,
    output logic                done,
    output logic                sck,
    output logic                cs,
    output logic                copi
);
    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam logic [HW-1:0] HMAX = HW'(CLK_DIV - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, TRAIL, GAP} state_t;
    state_t        state_q;
    logic [63:0]   sr_q;
    logic [HW-1:0] hcnt_q;
    logic [6:0]    bcnt_q;
    logic          sck_q, cs_q, busy_q, done_q, ready_q;
    logic          last;
    assign last = hcnt_q == HMAX;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            hcnt_q  <= '0;
            bcnt_q  <= '0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (req.req_valid && ready_q) begin
                    sr_q    <= {req.req_cmd, req.req_addr, req.req_data};
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    ready_q <= 1'b0;
                    hcnt_q  <= '0;
                    bcnt_q  <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: if (last) begin
                    hcnt_q <= '0;
                    sck_q  <= ~sck_q;
                    // falling edge: advance to the next bit; bit 0 stays on copi through TRAIL
                    if (sck_q) begin
                        bcnt_q <= bcnt_q + 7'd1;
                        if (bcnt_q == 7'd63) state_q <= TRAIL;
                        else sr_q <= {sr_q[62:0], 1'b0};
                    end
                end else hcnt_q <= hcnt_q + 1'b1;
                TRAIL: if (last) begin
                    hcnt_q  <= '0;
                    cs_q    <= 1'b1;
                    sr_q    <= '0;
                    state_q <= GAP;
                end else hcnt_q <= hcnt_q + 1'b1;
                GAP: if (last) begin
                    hcnt_q  <= '0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end else hcnt_q <= hcnt_q + 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req.req_ready = ready_q;
    assign busy = busy_q;
    assign done = done_q;
    assign sck  = sck_q;
    assign cs   = cs_q;
    assign copi = sr_q[63];
endmodule

// File: tb/tb_spi_write_master.sv
// tb_spi_write_master: directed frames on CLK_DIV=2 and CLK_DIV=1 instances, decoded by a sampling monitor.
module tb_spi_write_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_write_master_if ia ();
    spi_write_master_if ib ();
    logic [1:0] busy, done, sck, cs, copi;

    spi_write_master #(.CLK_DIV(2)) dut_a (
        .clk(clk), .rst(rst), .req(ia),
        .busy(busy[0]), .done(done[0]), .sck(sck[0]), .cs(cs[0]), .copi(copi[0])
    );
    spi_write_master #(.CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .req(ib),
        .busy(busy[1]), .done(done[1]), .sck(sck[1]), .cs(cs[1]), .copi(copi[1])
    );

    int vectors = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] exp_q [2][$];
    logic [63:0] sh [2];
    logic [63:0] e;
    int edges [2], low [2], hi [2], dn [2];
    logic psck [2], pdone [2], seen [2];

    initial for (int k = 0; k < 2; k++) dn[k] = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                sh[k] = '0; edges[k] = 0; low[k] = 0; hi[k] = 0;
                psck[k] = 1'b0; pdone[k] = 1'b0; seen[k] = 1'b0;
            end else begin
                if (cs[k] && sck[k]) chk("sck_while_deselected", 64'(sck[k]), 64'd0);
                if (done[k] && pdone[k]) chk("done_width", 64'(pdone[k]), 64'd0);
                if (done[k]) dn[k]++;
                if (!cs[k]) begin
                    if (low[k] == 0 && seen[k]) chk("cs_gap_min2", 64'(hi[k] >= 2), 64'd1);
                    low[k]++;
                    if (sck[k] && !psck[k]) begin
                        sh[k] = {sh[k][62:0], copi[k]};
                        edges[k]++;
                    end
                end else begin
                    if (low[k] != 0) begin
                        if (exp_q[k].size() == 0) chk("extra_frame", 64'(exp_q[k].size()), 64'd1);
                        else begin
                            e = exp_q[k].pop_front();
                            chk(k ? "frame_b" : "frame_a", sh[k], e);
                            chk(k ? "edges_b" : "edges_a", 64'(edges[k]), 64'd64);
                            chk(k ? "cs_low_b" : "cs_low_a", 64'(low[k]), k ? 64'd129 : 64'd258);
                        end
                        seen[k] = 1'b1; low[k] = 0; edges[k] = 0; sh[k] = '0; hi[k] = 0;
                    end
                    hi[k]++;
                end
                psck[k] = sck[k];
                pdone[k] = done[k];
            end
        end
    end

    task automatic drive(input int k, input logic v, input logic [63:0] f);
        if (k == 1) begin
            ib.req_valid = v; ib.req_cmd = f[63:56]; ib.req_addr = f[55:32]; ib.req_data = f[31:0];
        end else begin
            ia.req_valid = v; ia.req_cmd = f[63:56]; ia.req_addr = f[55:32]; ia.req_data = f[31:0];
        end
    endtask

    task automatic send(input int k, input logic [63:0] f);
        int n = 0;
        while (!(k == 1 ? ib.req_ready : ia.req_ready) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 64'(n < 2000), 64'd1);
        drive(k, 1'b1, f);
        exp_q[k].push_back(f);
        @(posedge clk); #1;
        drive(k, 1'b0, f);
        chk("busy_after_accept", 64'(busy[k]), 64'd1);
        chk("ready_after_accept", 64'(k == 1 ? ib.req_ready : ia.req_ready), 64'd0);
    endtask

    task automatic wait_done(input int k, input int maxc);
        int n = 0;
        while (!done[k] && n < maxc) begin
            @(posedge clk); #1; n++;
        end
        chk(k ? "done_b_seen" : "done_a_seen", 64'(done[k]), 64'd1);
    endtask

    initial begin
        int n;
        drive(0, 1'b0, 64'd0);
        drive(1, 1'b0, 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_ready", 64'(ia.req_ready), 64'd1);
        chk("rst_cs", 64'(cs[0]), 64'd1);
        chk("rst_sck", 64'(sck[0]), 64'd0);
        chk("rst_copi", 64'(copi[0]), 64'd0);
        chk("rst_busy", 64'(busy[0]), 64'd0);
        chk("rst_done", 64'(done[0]), 64'd0);

        // idle
        repeat (1000) @(posedge clk);
        #1;
        chk("idle_cs", 64'(cs), 64'd3);
        chk("idle_sck", 64'(sck), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done_count", 64'(dn[0] + dn[1]), 64'd0);

        // single frame
        send(0, 64'hA4123456DEADBEEF);
        wait_done(0, 400);

        // back-to-back: second request held valid across the busy period
        send(0, 64'h5A000001CAFEF00D);
        drive(0, 1'b1, 64'hA1ABCDEF01234567);
        exp_q[0].push_back(64'hA1ABCDEF01234567);
        n = 0;
        while (!ia.req_ready && n < 400) begin
            @(posedge clk); #1; n++;
        end
        chk("b2b_done_with_ready", 64'(done[0]), 64'd1);
        @(posedge clk); #1;
        drive(0, 1'b0, 64'd0);
        chk("b2b_busy", 64'(busy[0]), 64'd1);
        wait_done(0, 400);

        // input stability while busy
        send(0, 64'h3C00FF0055AA55AA);
        for (int i = 0; i < 10; i++) begin
            drive(0, 1'($urandom), {$urandom, $urandom});
            @(posedge clk); #1;
            chk("ready_low_busy", 64'(ia.req_ready), 64'd0);
        end
        drive(0, 1'b0, 64'd0);
        wait_done(0, 400);
        repeat (20) @(posedge clk);
        #1;
        chk("no_extra_pending", 64'(exp_q[0].size()), 64'd0);

        // reset in the middle of the frame
        send(0, 64'h0123456789ABCDEF);
        n = 0;
        while (edges[0] < 20 && n < 400) begin
            @(negedge clk); #1; n++;
        end
        chk("reach_edge20", 64'(edges[0]), 64'd20);
        rst = 1'b1;
        #1;
        chk("async_cs", 64'(cs[0]), 64'd1);
        chk("async_sck", 64'(sck[0]), 64'd0);
        chk("async_copi", 64'(copi[0]), 64'd0);
        exp_q[0].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ia.req_ready), 64'd1);
        chk("post_rst_busy", 64'(busy[0]), 64'd0);
        send(0, 64'hFFFFFFFFFFFFFFFF);
        wait_done(0, 400);

        // CLK_DIV=1
        send(1, 64'hAAAAAAAAAAAAAAAA);
        wait_done(1, 300);
        send(1, 64'h0000000000000000);
        wait_done(1, 300);

        repeat (10) @(posedge clk);
        #1;
        chk("queue_a_empty", 64'(exp_q[0].size()), 64'd0);
        chk("queue_b_empty", 64'(exp_q[1].size()), 64'd0);
        chk("done_count_a", 64'(dn[0]), 64'd5);
        chk("done_count_b", 64'(dn[1]), 64'd2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
